// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud divisor helper,
// common to the TX path and the planned RX path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      STOP
   } uart_tx_state_e;

   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the last cycle of
// each bit period; clear holds it at zero between frames.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter that pops bytes from a synchronous FIFO with a
// one-cycle registered read and shifts them out LSB first on a registered tx.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  tx,
   output logic                  tx_busy
);

   localparam int            BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int            BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   generate
      if (BAUD_DIV < 2) begin : g_bad_baud_div
         $error("uart_tx_fifo: BAUD_DIV must be at least 2");
      end
   endgenerate

   uart_tx_state_e        state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  tx_q, tx_d;
   logic                  baud_clear, baud_en, tick;

   // Timer idles at zero until the start bit so every bit lasts exactly BAUD_DIV.
   assign baud_clear = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);
   assign baud_en    = !baud_clear;

   uart_baud_counter #(
      .DIV (BAUD_DIV)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .en    (baud_en),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      unique case (state_q)
         IDLE:    if (!fifo_empty) state_d = POP;
         POP:     state_d = LOAD;
         LOAD: begin
            shift_d = fifo_data;
            bit_d   = '0;
            state_d = START;
         end
         START:   if (tick) state_d = DATA;
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         STOP:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // tx is decoded from the next state so the flop output lines up with it.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   assign fifo_pop = (state_q == POP);
   assign tx_busy  = (state_q != IDLE);
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=10 with a behavioural FIFO that
// has a one-cycle registered read.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fifo_empty;
   logic       fifo_pop;
   logic [7:0] fifo_data;
   logic       tx;
   logic       tx_busy;

   logic [7:0] mem [0:15];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       mask_empty = 1'b0;
   int         cyc = 0;
   int         pop_total = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   assign fifo_empty = (wr_ptr == rd_ptr) || mask_empty;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_pop === 1'b1) begin
         pop_total <= pop_total + 1;
         if (rd_ptr != wr_ptr) begin
            fifo_data <= mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
         end else begin
            fifo_data <= 8'hEE;
         end
      end
   end

   uart_tx_fifo #(
      .CLK_FREQ   (100),
      .BAUD_RATE  (10),
      .DATA_WIDTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .fifo_data  (fifo_data),
      .tx         (tx),
      .tx_busy    (tx_busy)
   );

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 16] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic flush();
      wr_ptr = rd_ptr;
   endtask

   // Waits for a start bit, then samples the middle of every bit period.
   task automatic recv_byte(output logic [7:0] b, output int t_fall, output bit ok);
      int w;
      b = '0;
      t_fall = -1;
      ok = 1'b0;
      for (w = 0; w < 400; w++) begin
         @(negedge clk);
         if (tx === 1'b0) break;
      end
      if (w >= 400) return;
      t_fall = cyc;
      ok = 1'b1;
      repeat (5) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (10) @(negedge clk);
         b[i] = tx;
      end
      repeat (10) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({tx, fifo_pop, tx_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: tx/pop/busy=%b required 100", i, {tx, fifo_pop, tx_busy});
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({tx, fifo_pop, tx_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_after[%0d]: tx/pop/busy=%b required 100", i, {tx, fifo_pop, tx_busy});
         end
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] byte_v;
      logic       exp_tx, exp_pop, exp_busy;
      int         e_tx, e_pop, e_busy, busy_n, p0;
      byte_v = 8'hA5;
      e_tx = 0; e_pop = 0; e_busy = 0; busy_n = 0;
      @(negedge clk);
      p0 = pop_total;
      push(byte_v);
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         exp_pop  = (k == 1);
         exp_busy = (k <= 102);
         if (k >= 3 && k <= 12)       exp_tx = 1'b0;
         else if (k >= 13 && k <= 92) exp_tx = byte_v[(k - 13) / 10];
         else                         exp_tx = 1'b1;
         if (tx !== exp_tx)        e_tx++;
         if (fifo_pop !== exp_pop) e_pop++;
         if (tx_busy !== exp_busy) e_busy++;
         if (tx_busy === 1'b1)     busy_n++;
      end
      n_cmp++;
      if (e_tx != 0) begin
         n_err++;
         $display("FAIL single_tx_wave: %0d wrong cycles, required 0", e_tx);
      end
      n_cmp++;
      if (e_pop != 0) begin
         n_err++;
         $display("FAIL single_pop_wave: %0d wrong cycles, required 0", e_pop);
      end
      n_cmp++;
      if (e_busy != 0) begin
         n_err++;
         $display("FAIL single_busy_wave: %0d wrong cycles, required 0", e_busy);
      end
      n_cmp++;
      if (busy_n != 102) begin
         n_err++;
         $display("FAIL single_busy_len: %0d cycles, required 102", busy_n);
      end
      n_cmp++;
      if (pop_total - p0 != 1) begin
         n_err++;
         $display("FAIL single_pops: %0d, required 1", pop_total - p0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [3];
      logic [7:0] b [3];
      int         t [3];
      bit         ok [3];
      int         p0;
      exp_b = '{8'h00, 8'hFF, 8'h3C};
      @(negedge clk);
      flush();
      p0 = pop_total;
      for (int i = 0; i < 3; i++) push(exp_b[i]);
      for (int i = 0; i < 3; i++) recv_byte(b[i], t[i], ok[i]);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (!ok[i] || b[i] !== exp_b[i]) begin
            n_err++;
            $display("FAIL b2b_byte[%0d]: got %h framing_ok=%0d, required %h", i, b[i], ok[i], exp_b[i]);
         end
      end
      for (int i = 1; i < 3; i++) begin
         n_cmp++;
         if (t[i] - t[i-1] != 103) begin
            n_err++;
            $display("FAIL b2b_gap[%0d]: %0d cycles, required 103", i, t[i] - t[i-1]);
         end
      end
      for (int w = 0; w < 300 && tx_busy !== 1'b0; w++) @(negedge clk);
      repeat (20) @(negedge clk);
      n_cmp++;
      if (tx_busy !== 1'b0 || pop_total - p0 != 3) begin
         n_err++;
         $display("FAIL b2b_pops: busy=%b pops=%0d, required busy=0 pops=3", tx_busy, pop_total - p0);
      end
   endtask

   task automatic test_empty_fifo();
      int bad, p0;
      bad = 0;
      @(negedge clk);
      flush();
      p0 = pop_total;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if ({tx, fifo_pop, tx_busy} !== 3'b100) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL empty_idle: %0d non-idle cycles, required 0", bad);
      end
      n_cmp++;
      if (pop_total != p0) begin
         n_err++;
         $display("FAIL empty_pops: %0d, required 0", pop_total - p0);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      int         t, p0, bad;
      bit         ok;
      bad = 0;
      @(negedge clk);
      flush();
      p0 = pop_total;
      push(8'h55);
      push(8'h81);
      repeat (57) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({tx, fifo_pop, tx_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL midreset_hold[%0d]: tx/pop/busy=%b required 100", i, {tx, fifo_pop, tx_busy});
         end
      end
      reset = 1'b0;
      recv_byte(b, t, ok);
      n_cmp++;
      if (!ok || b !== 8'h81) begin
         n_err++;
         $display("FAIL midreset_next: got %h framing_ok=%0d, required 81", b, ok);
      end
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (k >= 10 && {tx, fifo_pop, tx_busy} !== 3'b100) bad++;
      end
      n_cmp++;
      if (bad != 0 || pop_total - p0 != 2) begin
         n_err++;
         $display("FAIL midreset_no_resend: busy cycles=%0d pops=%0d, required 0 and 2", bad, pop_total - p0);
      end
   endtask

   task automatic test_late_arrival();
      logic       samp [1:102];
      logic [7:0] got, b;
      int         p0, first_pop, bad, t;
      bit         frame_ok, ok;
      first_pop = -1;
      bad = 0;
      @(negedge clk);
      flush();
      repeat (20) @(negedge clk);
      p0 = pop_total;
      push(8'h3A);
      for (int k = 1; k <= 102; k++) begin
         @(negedge clk);
         samp[k] = tx;
         if (fifo_pop === 1'b1 && first_pop < 0) first_pop = k;
         if (k == 20) push(8'hC3);
         if (k >= 100)     mask_empty = 1'b1;
         else if (k >= 20) mask_empty = ((k / 7) % 2 == 1);
      end
      frame_ok = (samp[8] === 1'b0) && (samp[98] === 1'b1);
      for (int i = 0; i < 8; i++) got[i] = samp[18 + 10 * i];
      n_cmp++;
      if (first_pop != 1) begin
         n_err++;
         $display("FAIL late_pop_latency: first pop at %0d, required 1", first_pop);
      end
      n_cmp++;
      if (!frame_ok || got !== 8'h3A) begin
         n_err++;
         $display("FAIL late_byte: got %h framing_ok=%0d, required 3a", got, frame_ok);
      end
      n_cmp++;
      if (pop_total - p0 != 1) begin
         n_err++;
         $display("FAIL late_pops_in_frame: %0d, required 1", pop_total - p0);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (tx_busy !== 1'b0 || fifo_pop !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL late_masked_idle: %0d active cycles, required 0", bad);
      end
      mask_empty = 1'b0;
      recv_byte(b, t, ok);
      for (int w = 0; w < 300 && tx_busy !== 1'b0; w++) @(negedge clk);
      n_cmp++;
      if (!ok || b !== 8'hC3 || pop_total - p0 != 2) begin
         n_err++;
         $display("FAIL late_second: got %h framing_ok=%0d pops=%0d, required c3 and 2", b, ok, pop_total - p0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_empty_fifo();
      test_reset_mid_frame();
      test_late_arrival();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
